instr_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core, directly upstream of the controller and datapath. It holds the PC, fetches one instruction word per instruction from a variable-latency instruction memory over a req/ack handshake, and presents it as `instr`/`instr_valid` to the decode and execute logic. When execute accepts the instruction, the unit takes the controller's flow-control decisions (`branch`, `jump`, `jump_reg`, `is_syscall`) plus datapath results and computes the next PC. It halts permanently on `syscall` or on a misaligned target.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch stage with PC, req/ack fetch and next-PC selection
//
// Purpose:
//   Holds the PC, fetches one instruction word per instruction over a
//   variable-latency req/ack memory handshake, presents it to decode/execute
//   and, on accept, computes the next PC from the controller's flow decisions.
//   Halts permanently on syscall or when a misaligned target would be taken.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req / imem_addr      fetch request (held until ack) and word address (= pc)
//   imem_ack / imem_rdata     memory response, data valid only with ack
//   instr / instr_valid       latched instruction and its valid flag for execute
//   instr_accept              execute retires instr; flow inputs sampled this cycle
//   branch, jump, jump_reg,
//   is_syscall, alu_zero      controller / datapath flow decisions
//   rs_data                   GPR[rs], the jr target
//   pc / pc_plus4             current instruction address and pc + 4
//   halted / fetch_error      stopped, and stopped because of a misaligned target
//   retired_count             accepted-instruction counter, wraps modulo 2^32

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        is_syscall,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fetch_error,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        r_req;
    logic        r_valid;
    logic        r_halted;
    logic        r_fetch_error;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic        w_misaligned;

    // Sequential PC, wraps naturally at 2^32.
    assign w_pc_plus4    = r_pc + 32'd4;

    // Sign-extended word offset of beq, already shifted to a byte offset.
    assign w_br_offset   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // j keeps the top nibble of the delay-slot address (pc + 4).
    assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Next-PC priority: jr over j over taken branch over fall-through.
    // Syscall has top priority but does not need a target, so it is
    // handled directly in the FSM.
    always_comb begin
        w_target = w_pc_plus4;
        if (jump_reg) begin
            w_target = rs_data;
        end else if (jump) begin
            w_target = w_jump_target;
        end else if (branch && alu_zero) begin
            w_target = w_pc_plus4 + w_br_offset;
        end
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);

    // Single FSM with registered handshake outputs: no combinational path
    // from imem_ack or instr_accept reaches any output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_retired     <= 32'd0;
            r_req         <= 1'b0;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end

                ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (instr_accept) begin
                        r_retired <= r_retired + 32'd1;
                        r_valid   <= 1'b0;
                        if (is_syscall) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (w_misaligned) begin
                            // pc is left on the offending instruction for debug.
                            r_fetch_error <= 1'b1;
                            r_halted      <= 1'b1;
                            r_state       <= ST_HALT;
                        end else begin
                            r_pc    <= w_target;
                            r_req   <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                ST_HALT: begin
                    // Absorbing: only reset leaves this state.
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = r_req;
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = r_valid;
    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign halted        = r_halted;
    assign fetch_error   = r_fetch_error;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with a behavioural next-PC model

module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        is_syscall = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fetch_error;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;
    logic        m_halted;
    logic        m_ferr;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_accept  (instr_accept),
        .branch        (branch),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .is_syscall    (is_syscall),
        .alu_zero      (alu_zero),
        .rs_data       (rs_data),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .fetch_error   (fetch_error),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack     = 1'b0;
        instr_accept = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        is_syscall   = 1'b0;
        alu_zero     = 1'b0;
    endtask

    task automatic random_flow_noise();
        branch     = 1'($urandom);
        jump       = 1'($urandom);
        jump_reg   = 1'($urandom);
        is_syscall = 1'($urandom);
        alu_zero   = 1'($urandom);
        rs_data    = $urandom;
    endtask

    // Reset, check reset state (this is also the IDLE cycle), release reset.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        check_eq("rst_req",   32'(imem_req),    32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_halt",  32'(halted),      32'd0);
        check_eq("rst_ferr",  32'(fetch_error), 32'd0);
        check_eq("rst_pc",    pc,               RST_PC);
        check_eq("rst_instr", instr,            32'd0);
        check_eq("rst_ret",   retired_count,    32'd0);
        rst       = 1'b0;
        m_pc      = RST_PC;
        m_instr   = 32'd0;
        m_retired = 32'd0;
        m_halted  = 1'b0;
        m_ferr    = 1'b0;
        step();
    endtask

    // Serve one fetch after `waits` cycles without ack; DUT must be in FETCH on entry.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            check_eq("wait_req",   32'(imem_req),    32'd1);
            check_eq("wait_addr",  imem_addr,        m_pc);
            check_eq("wait_valid", 32'(instr_valid), 32'd0);
            step();
        end
        check_eq("fetch_req",  32'(imem_req), 32'd1);
        check_eq("fetch_addr", imem_addr,     m_pc);
        check_eq("fetch_pc4",  pc_plus4,      m_pc + 32'd4);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        check_eq("exec_valid", 32'(instr_valid), 32'd1);
        check_eq("exec_req",   32'(imem_req),    32'd0);
        check_eq("exec_instr", instr,            m_instr);
    endtask

    // Hold in EXEC for `delay` cycles (with ignored flow noise), then accept.
    task automatic do_exec(input int delay, input logic sys, input logic jr, input logic j,
                           input logic br, input logic zero, input logic [31:0] rs);
        logic [31:0]        pc4;
        logic [31:0]        tgt;
        logic signed [31:0] off;
        for (int i = 0; i < delay; i++) begin
            random_flow_noise();
            step();
            check_eq("hold_valid", 32'(instr_valid), 32'd1);
            check_eq("hold_instr", instr,            m_instr);
            check_eq("hold_pc",    pc,               m_pc);
        end
        is_syscall   = sys;
        jump_reg     = jr;
        jump         = j;
        branch       = br;
        alu_zero     = zero;
        rs_data      = rs;
        instr_accept = 1'b1;
        step();
        clear_inputs();

        pc4 = m_pc + 32'd4;
        off = $signed(m_instr[15:0]);
        m_retired = m_retired + 32'd1;
        if (sys) begin
            m_halted = 1'b1;
        end else begin
            if (jr)
                tgt = rs;
            else if (j)
                tgt = (pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
            else if (br && zero)
                tgt = pc4 + 32'(off * 4);
            else
                tgt = pc4;
            if (tgt % 4 != 0) begin
                m_halted = 1'b1;
                m_ferr   = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end
        check_eq("acc_halt",  32'(halted),      32'(m_halted));
        check_eq("acc_ferr",  32'(fetch_error), 32'(m_ferr));
        check_eq("acc_pc",    pc,               m_pc);
        check_eq("acc_ret",   retired_count,    m_retired);
        check_eq("acc_req",   32'(imem_req),    32'(!m_halted));
        check_eq("acc_valid", 32'(instr_valid), 32'd0);
    endtask

    // In HALT, random ack/accept/flow pulses must change nothing.
    task automatic check_absorb(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_ack     = 1'($urandom);
            imem_rdata   = $urandom;
            instr_accept = 1'($urandom);
            random_flow_noise();
            step();
            check_eq("halt_halt",  32'(halted),      32'd1);
            check_eq("halt_req",   32'(imem_req),    32'd0);
            check_eq("halt_valid", 32'(instr_valid), 32'd0);
            check_eq("halt_pc",    pc,               m_pc);
            check_eq("halt_ret",   retired_count,    m_retired);
            check_eq("halt_ferr",  32'(fetch_error), 32'(m_ferr));
            check_eq("halt_instr", instr,            m_instr);
        end
        clear_inputs();
    endtask

    task automatic goto_pc(input logic [31:0] target);
        do_reset();
        do_fetch(0, $urandom);
        do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, target);
    endtask

    initial begin
        logic [31:0] w;

        // Sequential run, zero-wait ack, accept on first valid cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check_eq("seq_addr", imem_addr, RST_PC + 32'(4 * i));
            do_fetch(0, $urandom & 32'h03FF_FFFF);
            do_exec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        end
        check_eq("seq_ret3", retired_count, 32'd3);

        // Wait states
        do_fetch(4, $urandom);
        do_exec(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("ws_pc", pc, 32'h0000_3010);

        // Flow control from 0x3010
        goto_pc(32'h3010);
        w = {6'h04, 5'd1, 5'd2, 16'hFFFC};
        do_fetch(0, w);
        do_exec(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        check_eq("beq_taken", pc, 32'h0000_3004);

        goto_pc(32'h3010);
        do_fetch(0, w);
        do_exec(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("beq_not", pc, 32'h0000_3014);

        goto_pc(32'h3010);
        do_fetch(0, {6'h02, 26'h0000C10});
        do_exec(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check_eq("j_tgt", pc, 32'h0000_3040);

        goto_pc(32'h3010);
        do_fetch(0, $urandom);
        do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3100);
        check_eq("jr_tgt", pc, 32'h0000_3100);

        // Priority: jump_reg over jump
        goto_pc(32'h3010);
        do_fetch(0, {6'h02, 26'h0000C10});
        do_exec(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3200);
        check_eq("prio_jr", pc, 32'h0000_3200);

        // Misaligned jr
        goto_pc(32'h3010);
        do_fetch(0, $urandom);
        do_exec(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3102);
        check_eq("mis_ferr", 32'(fetch_error), 32'd1);
        check_eq("mis_pc",   pc,               32'h0000_3010);
        check_absorb(4);

        // PC wrap
        goto_pc(32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc_plus4, 32'd0);
        do_fetch(0, 32'd0);
        do_exec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("wrap_pc", pc, 32'd0);

        // Syscall with higher priority than everything else
        do_fetch(1, $urandom);
        do_exec(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
        check_eq("sys_halt", 32'(halted), 32'd1);
        check_absorb(10);

        // Reset mid-FETCH with a late ack during IDLE
        do_reset();
        do_fetch(0, 32'h1234_5678);
        do_exec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("mid_req_pre", 32'(imem_req), 32'd1);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        check_eq("mid_idle_req", 32'(imem_req), 32'd0);
        step();
        imem_ack = 1'b0;
        m_pc = RST_PC; m_instr = 32'd0; m_retired = 32'd0; m_halted = 1'b0; m_ferr = 1'b0;
        check_eq("mid_req",   32'(imem_req),    32'd1);
        check_eq("mid_addr",  imem_addr,        RST_PC);
        check_eq("mid_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_instr", instr,            32'd0);
        check_eq("mid_ret",   retired_count,    32'd0);
        do_fetch(2, 32'h0BAD_F00D);

        // Randomized runs against the model
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int k = 0; k < 40 && !m_halted; k++) begin
                logic [31:0] rs;
                rs = $urandom;
                if ($urandom_range(0, 7) != 0)
                    rs[1:0] = 2'b00;
                do_fetch($urandom_range(0, 3), $urandom);
                do_exec($urandom_range(0, 2),
                        ($urandom_range(0, 29) == 0),
                        ($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 4) == 0),
                        ($urandom_range(0, 2) == 0),
                        1'($urandom),
                        rs);
            end
            if (m_halted)
                check_absorb(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
